// File: rtl/lfsr_cipher_pkg.sv
// rtl/lfsr_cipher_pkg.sv - shared types, tap masks, S-box and LFSR step helper for the stream cipher
package lfsr_cipher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam int LFSR_BITS = 8;

    // Element i is the Fibonacci tap mask of LFSR i.
    localparam logic [3:0][LFSR_BITS-1:0] TAP = {8'hB1, 8'hB2, 8'hB4, 8'hB8};

    // PRESENT S-box, element n is S(n).
    localparam logic [15:0][3:0] SBOX = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
    };

    function automatic logic [3:0] sbox_nibble(input logic [3:0] n);
        return SBOX[n];
    endfunction

    function automatic logic [LFSR_BITS-1:0] lfsr_step(input logic [LFSR_BITS-1:0] s,
                                                      input logic [LFSR_BITS-1:0] mask);
        logic fb;
        fb = ^(s & mask);
        return {s[LFSR_BITS-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_unit.sv
// rtl/lfsr_unit.sv - one Fibonacci LFSR with key^iv seeding, zero-seed guard and step enable
module lfsr_unit
    import lfsr_cipher_pkg::*;
#(
    parameter int                LFSR_W   = 8,
    parameter logic [LFSR_W-1:0] TAP_MASK = 8'hB8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_en,
    input  logic              step_en,
    input  logic [LFSR_W-1:0] key_slice,
    input  logic [LFSR_W-1:0] iv_slice,
    output logic [LFSR_W-1:0] lfsr_state
);

    logic [LFSR_W-1:0] seed;

    assign seed = key_slice ^ iv_slice;

    // An all-zero state would lock the register, so such seeds become 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_state <= '0;
        end else if (seed_en) begin
            lfsr_state <= (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
        end else if (step_en) begin
            lfsr_state <= lfsr_step(lfsr_state, TAP_MASK);
        end
    end

endmodule

// File: rtl/lfsr_stream_cipher_core.sv
// rtl/lfsr_stream_cipher_core.sv - multi-LFSR streaming cipher core; STREAM_CIPHER_WORD_COUNT_EN adds word_count
module lfsr_stream_cipher_core
    import lfsr_cipher_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_LFSR = 3,
    parameter int LFSR_W   = 8,
    parameter int WARMUP   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LFSR*LFSR_W-1:0] key,
    input  logic [NUM_LFSR*LFSR_W-1:0] iv,
    input  logic                       load,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data
`ifdef STREAM_CIPHER_WORD_COUNT_EN
    ,
    output logic [31:0]                word_count
`endif
);

    localparam logic [15:0] WARMUP_LAST = 16'(WARMUP - 1);

    state_t            state;
    logic [15:0]       warm_cnt;
    logic              handshake;
    logic              seed_en;
    logic              step_en;
    logic [LFSR_W-1:0] lfsr_q [NUM_LFSR];
    logic [LFSR_W-1:0] mix;
    logic [WIDTH-1:0]  ks;

    assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready) && !load;
    assign handshake = in_valid && in_ready;
    assign seed_en   = (state == ST_LOAD);
    assign step_en   = ((state == ST_WARMUP) && !load) || handshake;
    assign busy      = (state == ST_LOAD) || (state == ST_WARMUP);

    generate
        for (genvar i = 0; i < NUM_LFSR; i++) begin : g_lfsr
            lfsr_unit #(
                .LFSR_W  (LFSR_W),
                .TAP_MASK(TAP[i])
            ) u_lfsr (
                .clk       (clk),
                .rst       (rst),
                .seed_en   (seed_en),
                .step_en   (step_en),
                .key_slice (key[i*LFSR_W +: LFSR_W]),
                .iv_slice  (iv[i*LFSR_W +: LFSR_W]),
                .lfsr_state(lfsr_q[i])
            );
        end
    endgenerate

    always_comb begin
        mix = '0;
        for (int i = 0; i < NUM_LFSR; i++) begin
            mix = mix ^ lfsr_q[i];
        end
    end

    always_comb begin
        ks = '0;
        for (int n = 0; n < WIDTH / 4; n++) begin
            ks[n*4 +: 4] = sbox_nibble(mix[n*4 +: 4]);
        end
    end

    // A load pulse overrides everything, including a word offered in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            warm_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            state     <= ST_LOAD;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    warm_cnt <= '0;
                    state    <= ST_WARMUP;
                end
                ST_WARMUP: begin
                    warm_cnt <= warm_cnt + 16'd1;
                    if (warm_cnt == WARMUP_LAST) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        out_data  <= in_data ^ ks;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

`ifdef STREAM_CIPHER_WORD_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count <= '0;
        end else if (state == ST_LOAD) begin
            word_count <= '0;
        end else if (handshake && (word_count != 32'hFFFF_FFFF)) begin
            word_count <= word_count + 32'd1;
        end
    end
`endif

endmodule
